rr_priority_arbiter: RTL and testbench

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

---
 rtl/arb_pkg.sv | 6 +
 rtl/priority_encoder_n.sv | 16 +
 rtl/rr_priority_arbiter.sv | 57 +++++
 tb/tb_rr_priority_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared mode constants and state encoding for the arbiter
package arb_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/priority_encoder_n.sv
// priority_encoder_n: highest-index-wins binary encoder with any-valid flag
module priority_encoder_n #(
  parameter int N = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  d,
  output logic [IW-1:0] q,
  output logic          v
);
  // later set bits overwrite earlier ones, so the highest set index wins
  always_comb begin
    q = '0;
    v = |d;
    for (int i = 0; i < N; i++) if (d[i]) q = IW'(i);
  end
endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: fixed-priority / round-robin arbiter with held grants and registered outputs
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  state_t state;
  logic [IW-1:0] ptr, q, win, nxt_ptr;
  logic [IW:0] off, sum;
  logic [N-1:0] cand, rot, enc_in;
  logic v, arb;
  int j;
  // the releasing holder is masked out; round-robin reverses the ptr rotation so the
  // encoder's highest-index preference becomes "first at or after ptr"
  always_comb begin
    arb = state == IDLE || ack || !req[gnt_idx];
    cand = state == BUSY ? req & ~gnt : req;
    rot = '0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      rot[N-1-i] = cand[j >= N ? j - N : j];
    end
    enc_in = mode == MODE_RR ? rot : cand;
    off = (IW+1)'(N - 1) - {1'b0, q};
    sum = {1'b0, ptr} + off;
    win = mode == MODE_RR ? (sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : IW'(sum)) : q;
    nxt_ptr = win == IW'(N - 1) ? '0 : win + 1'b1;
  end
  priority_encoder_n #(.N(N), .IW(IW)) u_enc (.d(enc_in), .q(q), .v(v));
  // grant state machine: arbitrate in IDLE or on release, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      ptr <= '0;
    end else if (arb) begin
      state <= v ? BUSY : IDLE;
      gnt <= v ? N'(1) << win : '0;
      gnt_idx <= v ? win : '0;
      gnt_valid <= v;
      if (v) ptr <= nxt_ptr;
    end
  end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_rr_priority_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic [N-1:0] req = '0;
  logic ack = 1'b0;
  logic [N-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic gnt_valid;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit m_valid = 0;
  int m_idx = 0;
  int m_ptr = 0;

  rr_priority_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .req(req), .ack(ack),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [N-1:0] q, input logic a);
    reset = r;
    mode = m;
    req = q;
    ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  // behavioural model: who should hold the grant after this edge
  always @(posedge clk) begin
    bit [N-1:0] cand;
    int w;
    started = 1;
    if (reset) begin
      m_valid = 0;
      m_idx = 0;
      m_ptr = 0;
    end else if (!m_valid || ack || !req[m_idx]) begin
      cand = req;
      if (m_valid) cand[m_idx] = 1'b0;
      w = -1;
      if (mode) begin
        for (int k = 0; k < N; k++)
          if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (w < 0 && cand[k]) w = k;
      end
      if (w >= 0) begin
        m_valid = 1;
        m_idx = w;
        m_ptr = (w + 1) % N;
      end else begin
        m_valid = 0;
        m_idx = 0;
      end
    end
  end

  // every-cycle comparison of the DUT against the model, plus the one-hot invariant
  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", 32'(gnt_valid), 32'(m_valid));
      chk("model_idx", 32'(gnt_idx), 32'(m_idx));
      chk("model_gnt", 32'(gnt), m_valid ? 32'(1) << m_idx : 32'(0));
      chk("onehot_inv", 32'(gnt), gnt_valid ? 32'(1) << gnt_idx : 32'(0));
    end
  end

  initial begin
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b0000, 0);
      chk("idle_valid", 32'(gnt_valid), 0);
      chk("idle_gnt", 32'(gnt), 0);
    end
    step(0, 0, 4'b1010, 0);
    chk("fixed_gnt", 32'(gnt), 32'b1000);
    chk("fixed_idx", 32'(gnt_idx), 3);
    step(0, 0, 4'b1010, 1);
    chk("fixed_ack_gnt", 32'(gnt), 32'b0010);
    chk("fixed_ack_idx", 32'(gnt_idx), 1);
    step(0, 0, 4'b0000, 0);
    chk("fixed_drop_valid", 32'(gnt_valid), 0);
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b1111, 0);
    chk("rr_seq0", 32'(gnt_idx), 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 4'b1111, 1);
      chk("rr_seq_idx", 32'(gnt_idx), 32'(i % 4));
      chk("rr_seq_valid", 32'(gnt_valid), 1);
    end
    step(0, 1, 4'b0100, 1);
    chk("rr_idx2", 32'(gnt_idx), 2);
    step(0, 1, 4'b0000, 0);
    chk("rr_drop_valid", 32'(gnt_valid), 0);
    chk("rr_drop_gnt", 32'(gnt), 0);
    step(0, 1, 4'b0001, 0);
    chk("rr_regrant_idx", 32'(gnt_idx), 0);
    chk("rr_regrant_valid", 32'(gnt_valid), 1);
    step(0, 1, 4'b1000, 0);
    chk("hold3_idx", 32'(gnt_idx), 3);
    step(1, 1, 4'b1000, 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_valid", 32'(gnt_valid), 0);
    step(0, 1, 4'b1111, 0);
    chk("post_rst_idx", 32'(gnt_idx), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1'(i), {3'($urandom_range(0, 7)), 1'b1}, 0);
      chk("hold_gnt", 32'(gnt), 32'b0001);
    end
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom), 4'($urandom),
           $urandom_range(0, 2) == 0);
    end
    step(0, 0, 4'b0000, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
